// File: rtl/config_stream_loader_pkg.sv
// Shared types and constants for the config chain loader.
// Holds the FSM state type, chain sizing constants and a words-per-load helper.
package config_stream_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    FINISH
  } state_t;

  localparam int BITS_PER_TILE = 524;
  localparam int TILE_COUNT    = 1;
  localparam int DEF_CHAIN_LEN = TILE_COUNT * BITS_PER_TILE;

  function automatic int words_per_load(
    input int chain_bits,
    input int word_bits
  );
    return (chain_bits + word_bits - 1) / word_bits;
  endfunction

endpackage

// File: rtl/config_stream_loader_if.sv
// Bitstream word handshake between a host/boot source and the loader.
// master = word source (drives data/valid), slave = loader (drives ready).
interface config_stream_loader_if #(
  parameter int WORD_WIDTH = 32
);

  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/config_word_serializer.sv
// Word register plus bit index; presents word[bit_index], MSB first.
// Ports: load (capture word_in), shift (step index down), bit_out, last_bit.
module config_word_serializer
  import config_stream_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic                  bit_out,
  output logic                  last_bit
);

  localparam int IW =
    (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] word_q;
  logic [IW-1:0]         bit_index;

  assign bit_out  = word_q[bit_index];
  assign last_bit = (bit_index == '0);

  // A load in the same cycle as a shift wins: the old word's
  // bit 0 is being presented while the new word is captured.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      word_q    <= '0;
      bit_index <= '0;
    end else if (load) begin
      word_q    <= word_in;
      bit_index <= IW'(WORD_WIDTH - 1);
    end else if (shift) begin
      bit_index <= bit_index - IW'(1);
    end
  end

endmodule

// File: rtl/config_stream_loader.sv
// Writer end of the tile config chain: serialises words onto config_out.
// Ports: clock, nreset, start, abort, word_bus (slave), config_out/enable, busy, done.
module config_stream_loader
  import config_stream_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = DEF_CHAIN_LEN,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   start,
  input  logic                   abort,
  config_stream_loader_if.slave  word_bus,
  output logic                   config_out,
  output logic                   config_enable,
  output logic                   busy,
  output logic                   done
);

  localparam logic [COUNT_WIDTH-1:0] LAST_CNT =
    COUNT_WIDTH'(CHAIN_LENGTH - 1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] bits_sent;
  logic                   ser_bit;
  logic                   last_bit;
  logic                   final_bit;
  logic                   hs;

  assign final_bit = (bits_sent == LAST_CNT);

  // Ready only while waiting for a word or on a word's last bit
  // when more chain bits remain; abort suppresses any handshake.
  assign word_bus.word_ready = !abort && (
    (state == FETCH) ||
    (state == SHIFT && last_bit && !final_bit));

  assign hs = word_bus.word_valid && word_bus.word_ready;

  config_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_ser (
    .clock    (clock),
    .nreset   (nreset),
    .load     (hs),
    .shift    (state == SHIFT),
    .word_in  (word_bus.word_data),
    .bit_out  (ser_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      bits_sent     <= '0;
      config_out    <= 1'b0;
      config_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state         <= IDLE;
        config_enable <= 1'b0;
        busy          <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state     <= FETCH;
              busy      <= 1'b1;
              bits_sent <= '0;
            end
          end
          FETCH: begin
            config_enable <= 1'b0;
            if (hs) state <= SHIFT;
          end
          SHIFT: begin
            config_out    <= ser_bit;
            config_enable <= 1'b1;
            bits_sent     <= bits_sent + COUNT_WIDTH'(1);
            // Leftover word bits past the chain end are dropped.
            if (final_bit)
              state <= FINISH;
            else if (last_bit && !hs)
              state <= FETCH;
          end
          FINISH: begin
            config_enable <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
